// File: rtl/dn_port_arbiter.sv
// rtl/dn_port_arbiter.sv - boot ROM copy sequencer and host download arbiter for the core write port
// Optional feature macro: PALETTE_LOAD_EN (host index-3 bytes shift into the palette register)
module dn_port_arbiter #(
    parameter int            BOOT_LEN  = 276,
    parameter logic [15:0]   EXEC_ADDR = 16'h0000,
    parameter logic [127:0]  PAL_RESET = 128'h00000032cd320000ff00ffff00000000
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          start,
    output logic [15:0]   rom_addr,
    input  logic [7:0]    rom_data,
    input  logic          ioctl_download,
    input  logic [7:0]    ioctl_index,
    input  logic          ioctl_wr,
    input  logic [15:0]   ioctl_addr,
    input  logic [7:0]    ioctl_data,
    input  logic          dn_wait,
    output logic          dn_go,
    output logic          dn_wr,
    output logic [15:0]   dn_addr,
    output logic [7:0]    dn_data,
    output logic          execute_enable,
    output logic [15:0]   execute_addr,
    output logic [127:0]  palette,
    output logic          busy,
    output logic          overrun
);

    typedef enum logic [2:0] {IDLE, FETCH, LATCH, WRITE, HOST, EXEC} state_t;

    localparam logic [15:0] LAST = 16'(BOOT_LEN - 1);

    state_t       state;
    logic [15:0]  cnt;
    logic         copy_active;
    logic         hold_v;
    logic [15:0]  hold_addr;
    logic [7:0]   hold_data;
    logic         host_strobe;
    logic         host_done;

    assign host_strobe    = ioctl_wr && ioctl_download && (ioctl_index == 8'd0);
    assign host_done      = (state == HOST) && !dn_wait;
    assign dn_wr          = ((state == WRITE) || (state == HOST)) && !dn_wait;
    assign rom_addr       = cnt;
    assign execute_enable = (state == EXEC);
    assign execute_addr   = EXEC_ADDR;
    assign busy           = (state != IDLE) || hold_v;
    assign dn_go          = copy_active || (ioctl_download && (ioctl_index == 8'd0));

    // Host capture: a single-entry hold buffer; a byte arriving while it is full is lost.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            hold_v    <= 1'b0;
            hold_addr <= 16'd0;
            hold_data <= 8'd0;
            overrun   <= 1'b0;
        end else begin
            if (host_strobe) begin
                if (hold_v) begin
                    overrun <= 1'b1;
                end else begin
                    hold_v    <= 1'b1;
                    hold_addr <= ioctl_addr;
                    hold_data <= ioctl_data;
                end
            end
            if (host_done) begin
                hold_v <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 16'd0;
            copy_active <= 1'b0;
            dn_addr     <= 16'd0;
            dn_data     <= 8'd0;
        end else if (start) begin
            cnt         <= 16'd0;
            copy_active <= 1'b1;
            if (hold_v && !host_done) begin
                state   <= HOST;
                dn_addr <= hold_addr;
                dn_data <= hold_data;
            end else begin
                state <= FETCH;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (hold_v) begin
                        state   <= HOST;
                        dn_addr <= hold_addr;
                        dn_data <= hold_data;
                    end
                end
                FETCH: state <= LATCH;
                LATCH: begin
                    // ROM data for cnt is valid this cycle (one-cycle read latency)
                    dn_addr <= cnt;
                    dn_data <= rom_data;
                    state   <= WRITE;
                end
                WRITE: begin
                    if (!dn_wait) begin
                        if (cnt == LAST) begin
                            state <= EXEC;
                        end else begin
                            cnt <= cnt + 16'd1;
                            if (hold_v) begin
                                state   <= HOST;
                                dn_addr <= hold_addr;
                                dn_data <= hold_data;
                            end else begin
                                state <= FETCH;
                            end
                        end
                    end
                end
                HOST: begin
                    if (!dn_wait) begin
                        state <= copy_active ? FETCH : IDLE;
                    end
                end
                EXEC: begin
                    copy_active <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PALETTE_LOAD_EN
    logic          pal_strobe;
    logic [127:0]  palette_q;

    assign pal_strobe = ioctl_wr && ioctl_download && (ioctl_index == 8'd3);
    assign palette    = palette_q;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            palette_q <= PAL_RESET;
        end else if (pal_strobe) begin
            palette_q <= {palette_q[119:0], ioctl_data};
        end
    end
`else
    assign palette = PAL_RESET;
`endif

endmodule

// File: tb/tb_dn_port_arbiter.sv
// tb/tb_dn_port_arbiter.sv - self-checking bench for dn_port_arbiter
module tb_dn_port_arbiter;

    localparam int           BOOT_LEN  = 4;
    localparam logic [127:0] PAL_RESET = 128'h00000032cd320000ff00ffff00000000;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    typedef struct packed {
        logic wr;
        logic exe;
        logic go;
        logic busy;
    } vec_t;

    logic          clk_sys = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [15:0]   rom_addr;
    logic [7:0]    rom_data;
    logic          ioctl_download = 1'b0;
    logic [7:0]    ioctl_index = 8'd0;
    logic          ioctl_wr = 1'b0;
    logic [15:0]   ioctl_addr = 16'd0;
    logic [7:0]    ioctl_data = 8'd0;
    logic          dn_wait = 1'b0;
    logic          dn_go;
    logic          dn_wr;
    logic [15:0]   dn_addr;
    logic [7:0]    dn_data;
    logic          execute_enable;
    logic [15:0]   execute_addr;
    logic [127:0]  palette;
    logic          busy;
    logic          overrun;

    logic [7:0]    rom [0:3];
    wr_t           exp_q[$];
    int            tests = 0;
    int            fails = 0;

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) rom_data <= rom[rom_addr[1:0]];

    dn_port_arbiter #(.BOOT_LEN(BOOT_LEN), .EXEC_ADDR(16'h0000), .PAL_RESET(PAL_RESET)) dut (
        .clk_sys(clk_sys), .reset(reset), .start(start),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .ioctl_download(ioctl_download), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data),
        .dn_wait(dn_wait), .dn_go(dn_go), .dn_wr(dn_wr), .dn_addr(dn_addr), .dn_data(dn_data),
        .execute_enable(execute_enable), .execute_addr(execute_addr),
        .palette(palette), .busy(busy), .overrun(overrun)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the next expected write.
    always @(negedge clk_sys) begin
        wr_t e;
        if (!reset && dn_wr) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected none", dn_addr, dn_data);
            end else begin
                e = exp_q.pop_front();
                chk("sb_addr", dn_addr, e.addr);
                chk("sb_data", dn_data, e.data);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic push_wr(input logic [15:0] a, input logic [7:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic push_boot(input int first, input int last);
        for (int i = first; i <= last; i++) push_wr(16'(i), rom[i]);
    endtask

    task automatic apply_reset(input string tag);
        #1 reset = 1'b1;
        #1;
        chk({tag, "_dn_go"}, dn_go, 0);
        chk({tag, "_dn_wr"}, dn_wr, 0);
        chk({tag, "_exec"}, execute_enable, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_overrun"}, overrun, 0);
        chk({tag, "_dn_addr"}, dn_addr, 0);
        chk({tag, "_dn_data"}, dn_data, 0);
        chk({tag, "_rom_addr"}, rom_addr, 0);
        chk({tag, "_palette"}, palette, PAL_RESET);
        exp_q.delete();
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        next_cycle();
        start = 1'b0;
    endtask

    initial begin
        vec_t tbl [14];
        int   exec_c;
        int   wr_cnt;
        int   exe_cnt;

        rom[0] = 8'h11; rom[1] = 8'h22; rom[2] = 8'h33; rom[3] = 8'h44;
        // Per-cycle {dn_wr, execute_enable, dn_go, busy} for cycles 1..14 after start
        tbl = '{4'b0011, 4'b0011, 4'b1011, 4'b0011, 4'b0011, 4'b1011, 4'b0011,
                4'b0011, 4'b1011, 4'b0011, 4'b0011, 4'b1011, 4'b0111, 4'b0000};

        apply_reset("rst0");

        // Plain copy, cycle-exact
        push_boot(0, 3);
        pulse_start();
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk_sys);
            chk($sformatf("t1_wr_c%0d", c), dn_wr, tbl[c-1].wr);
            chk($sformatf("t1_exe_c%0d", c), execute_enable, tbl[c-1].exe);
            chk($sformatf("t1_go_c%0d", c), dn_go, tbl[c-1].go);
            chk($sformatf("t1_busy_c%0d", c), busy, tbl[c-1].busy);
            if (c == 13) chk("t1_exec_addr", execute_addr, 16'h0000);
            next_cycle();
        end
        chk("t1_sb_empty", exp_q.size(), 0);

        // dn_wait high for 5 cycles during WRITE of byte 1
        push_boot(0, 3);
        pulse_start();
        exec_c = -1;
        for (int c = 1; c <= 40 && exec_c < 0; c++) begin
            dn_wait = (c >= 6 && c <= 10);
            @(negedge clk_sys);
            if (c >= 6 && c <= 10) begin
                chk($sformatf("t2_nowr_c%0d", c), dn_wr, 0);
                chk($sformatf("t2_addr_c%0d", c), dn_addr, 16'd1);
                chk($sformatf("t2_data_c%0d", c), dn_data, 8'h22);
            end
            if (c == 11) chk("t2_wr_release", dn_wr, 1);
            if (execute_enable) exec_c = c;
            next_cycle();
        end
        dn_wait = 1'b0;
        chk("t2_exec_cycle", exec_c, 18);
        chk("t2_sb_empty", exp_q.size(), 0);
        next_cycle();

        // Host byte captured during LATCH of byte 2
        push_boot(0, 2);
        push_wr(16'h1234, 8'hA5);
        push_boot(3, 3);
        pulse_start();
        exec_c = -1;
        for (int c = 1; c <= 40 && exec_c < 0; c++) begin
            ioctl_download = 1'b1;
            ioctl_index = 8'd0;
            ioctl_wr = (c == 8);
            ioctl_addr = 16'h1234;
            ioctl_data = 8'hA5;
            @(negedge clk_sys);
            if (c == 9) chk("t3_byte2_wr", dn_wr, 1);
            if (c == 10) chk("t3_host_wr", dn_wr, 1);
            if (c == 11) chk("t3_resume_fetch", dn_wr, 0);
            if (execute_enable) exec_c = c;
            next_cycle();
        end
        ioctl_wr = 1'b0;
        ioctl_download = 1'b0;
        chk("t3_exec_cycle", exec_c, 14);
        chk("t3_sb_empty", exp_q.size(), 0);
        next_cycle();

        // Two host strobes while WRITE is stalled: second is lost
        push_boot(0, 0);
        push_wr(16'h4000, 8'h5A);
        push_boot(1, 3);
        pulse_start();
        exec_c = -1;
        for (int c = 1; c <= 40 && exec_c < 0; c++) begin
            dn_wait = (c >= 3 && c <= 6);
            ioctl_download = 1'b1;
            ioctl_index = 8'd0;
            ioctl_wr = (c == 3 || c == 5);
            ioctl_addr = (c == 3) ? 16'h4000 : 16'h5555;
            ioctl_data = (c == 3) ? 8'h5A : 8'h77;
            @(negedge clk_sys);
            if (c == 4) chk("t4_overrun_pre", overrun, 0);
            if (c == 6) chk("t4_overrun_set", overrun, 1);
            if (execute_enable) exec_c = c;
            next_cycle();
        end
        dn_wait = 1'b0;
        ioctl_wr = 1'b0;
        ioctl_download = 1'b0;
        chk("t4_exec_cycle", exec_c, 18);
        chk("t4_sb_empty", exp_q.size(), 0);
        repeat (3) next_cycle();
        chk("t4_overrun_sticky", overrun, 1);
        chk("t4_idle", busy, 0);
        apply_reset("rst1");

        // Palette strobes and an ignored index
        ioctl_download = 1'b1;
        ioctl_index = 8'd3;
        for (int i = 0; i < 16; i++) begin
            ioctl_wr = 1'b1;
            ioctl_data = 8'(i);
            next_cycle();
        end
        ioctl_wr = 1'b0;
        @(negedge clk_sys);
`ifdef PALETTE_LOAD_EN
        chk("t5_palette", palette, 128'h000102030405060708090A0B0C0D0E0F);
`else
        chk("t5_palette", palette, PAL_RESET);
`endif
        chk("t5_go_idx3", dn_go, 0);
        next_cycle();
        ioctl_index = 8'd5;
        ioctl_wr = 1'b1;
        next_cycle();
        ioctl_wr = 1'b0;
        @(negedge clk_sys);
        chk("t5_idx5_busy", busy, 0);
        ioctl_download = 1'b0;
        next_cycle();

        // Reset mid-copy during byte 2, then a fresh copy from address 0
        push_boot(0, 3);
        pulse_start();
        for (int c = 1; c < 8; c++) next_cycle();
        apply_reset("rst2");
        wr_cnt = 0;
        exe_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_sys);
            if (dn_wr) wr_cnt++;
            if (execute_enable) exe_cnt++;
            next_cycle();
        end
        chk("t6_no_wr_after_reset", wr_cnt, 0);
        chk("t6_no_exec_after_reset", exe_cnt, 0);
        push_boot(0, 3);
        pulse_start();
        exec_c = -1;
        for (int c = 1; c <= 40 && exec_c < 0; c++) begin
            @(negedge clk_sys);
            if (c == 1) chk("t6_restart_addr", rom_addr, 0);
            if (execute_enable) exec_c = c;
            next_cycle();
        end
        chk("t6_exec_cycle", exec_c, 13);
        chk("t6_sb_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dn_port_arbiter.md
# dn_port_arbiter

Sequencer and arbiter for the PCW core's single download write port (`dn_go/dn_wr/dn_addr/dn_data`). It copies the boot ROM image into CPU memory after every reset and then issues a one-cycle execute pulse. It also forwards host ROM downloads (ioctl index 0) onto the same port, with host bytes taking priority. Host palette bytes (index 3) are shifted into the 128-bit fake-colour palette register. It sits in the top level between `data_io`, the boot ROM and `pcw_core`.

## Interface
Parameters:
- `BOOT_LEN`, 276: number of boot ROM bytes copied (addresses 0..BOOT_LEN-1).
- `EXEC_ADDR`, 16'h0000: value driven on `execute_addr`.
- `PAL_RESET`, 128'h00000032cd320000ff00ffff00000000: palette reset value.

Ports:
- `clk_sys` in 1: system clock. All logic runs on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: one-cycle pulse that starts or restarts the boot copy.
- `rom_addr` out 16: boot ROM read address. The ROM is synchronous with 1-cycle read latency.
- `rom_data` in 8: boot ROM read data.
- `ioctl_download` in 1: host download active.
- `ioctl_index` in 8: host download index.
- `ioctl_wr` in 1: host byte strobe.
- `ioctl_addr` in 16: host byte address.
- `ioctl_data` in 8: host byte data.
- `dn_wait` in 1: core busy. While it is high, any pending write is held.
- `dn_go` out 1: download window active.
- `dn_wr` out 1: one-cycle write strobe.
- `dn_addr` out 16: write address.
- `dn_data` out 8: write data.
- `execute_enable` out 1: one-cycle pulse when the boot copy completes.
- `execute_addr` out 16: constant `EXEC_ADDR`.
- `palette` out 128: palette register.
- `busy` out 1: FSM not in IDLE, or a host byte is pending.
- `overrun` out 1: sticky flag, set when a host byte is lost.

## Operation
- FSM states: IDLE, FETCH, LATCH, WRITE, HOST, EXEC.
- IDLE:
  - If a host byte is held (`hold_v`), go to HOST.
  - Otherwise stay in IDLE.
- FETCH: drive `rom_addr = cnt`, then go to LATCH.
- LATCH: capture `rom_data` into the data register, then go to WRITE.
- WRITE: drive `dn_addr = cnt` and `dn_data = captured byte`.
  - `dn_wr` is asserted only in a cycle where `dn_wait` is low.
  - In that cycle: if `cnt == BOOT_LEN-1`, go to EXEC; otherwise `cnt <= cnt+1` and go to FETCH, or to HOST if `hold_v` is set.
- HOST: drive `dn_addr/dn_data` from the hold register.
  - `dn_wr` is asserted when `dn_wait` is low.
  - In that cycle `hold_v` is cleared and the FSM returns to FETCH if a copy is active, otherwise to IDLE.
- EXEC: `execute_enable = 1` for one cycle, then go to IDLE. The copy-active flag is cleared.
- Host capture:
  - On `ioctl_wr && ioctl_download && ioctl_index == 0`, `{ioctl_addr, ioctl_data}` is latched into the hold register and `hold_v` is set.
  - If `hold_v` is already set, the new byte is dropped, `overrun` is set, and the held byte is kept.
- Palette: on `ioctl_wr && ioctl_download && ioctl_index == 3`, `palette <= {palette[119:0], ioctl_data}`.
- All other indices are ignored.
- `dn_go` = copy-active OR (`ioctl_download && ioctl_index == 0`).
- `start` from any state: `cnt <= 0`, copy-active is set, FSM goes to FETCH (HOST if `hold_v` is set). `start` does not clear `hold_v`.
- `start` has priority over a simultaneous WRITE completion.

## Timing
- Reset values:
  - FSM = IDLE, `cnt` = 0, `hold_v` = 0.
  - `dn_go`, `dn_wr`, `execute_enable`, `busy`, `overrun` = 0.
  - `dn_addr` = 0, `dn_data` = 0, `rom_addr` = 0.
  - `palette = PAL_RESET`.
- Reset in the middle of a copy aborts immediately. No further `dn_wr` is issued until the next `start`.
- Boot byte latency with `dn_wait` low: 3 cycles per byte (FETCH, LATCH, WRITE).
- Whole copy: `start`, then the first `dn_wr` 3 cycles later, then `execute_enable` in cycle `3*BOOT_LEN+1` after `start`.
- Host byte: `dn_wr` occurs no earlier than 1 cycle after capture. It waits at most until the current WRITE finishes.
- `dn_wr` is never asserted in two consecutive cycles for the same byte.
- `dn_addr/dn_data` stay stable for as long as `dn_wait` is high.
- `cnt` is 16 bits wide and never wraps, because it is bounded by `BOOT_LEN-1`.

## Configuration
- `PALETTE_LOAD_EN`:
  - Defined: index-3 bytes shift into `palette`.
  - Undefined: `palette` is the constant `PAL_RESET`, index-3 strobes are ignored, and the palette shift register is not synthesised.

## Test plan
- Reset release, then `start` pulse, with `BOOT_LEN=4`, ROM = {11,22,33,44}, `dn_wait` = 0 -> `dn_wr` at cycles 3, 6, 9, 12 with addr 0..3 and data 11..44. `execute_enable` at cycle 13. `dn_go` falls at cycle 14.
- `dn_wait` held high for 5 cycles during the WRITE of byte 1 -> no `dn_wr`, addr/data held at 1/22. `dn_wr` fires in the first cycle `dn_wait` is low. Total cycle count grows by 5.
- Host strobe with index 0, addr 0x1234, data 0xA5 during the LATCH of byte 2 -> byte 2 is written first, then the host write 0x1234/0xA5, then the copy resumes at byte 3.
- Two index-0 host strobes 1 cycle apart while in WRITE with `dn_wait` high -> only the first is written, and `overrun` = 1 until reset.
- With `PALETTE_LOAD_EN` defined, 16 index-3 strobes with data 0x00..0x0F -> `palette` = 128'h000102030405060708090A0B0C0D0E0F. With it undefined, `palette` stays at `PAL_RESET`.
- `reset` asserted mid-copy at byte 2 -> all outputs take reset values asynchronously. No `execute_enable` occurs. A later `start` copies again from address 0.
